// File: rtl/aimbot_pkg.sv
// Shared types for the aiming pipeline: HDMI pack layout, bounding-box record, pack helpers.
package aimbot_pkg;

  localparam int H_ACT  = 1280;
  localparam int V_ACT  = 720;
  localparam int XW     = $clog2(H_ACT);
  localparam int YW     = $clog2(V_ACT);
  localparam int CW     = 8;
  localparam int CNT_W  = 24;
  localparam int PACK_W = 50;

  localparam logic [CW-1:0]    R_MIN      = 8'd160;
  localparam logic [CW-1:0]    G_MAX      = 8'd90;
  localparam logic [CW-1:0]    B_MAX      = 8'd90;
  localparam logic [CNT_W-1:0] MIN_PIXELS = 24'd64;
  localparam logic [3*CW-1:0]  BOX_RGB    = 24'h00FF00;

  typedef struct packed {
    logic          clk;
    logic          href;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } hdmi_t;

  typedef struct packed {
    logic             valid;
    logic [XW-1:0]    x0;
    logic [XW-1:0]    x1;
    logic [YW-1:0]    y0;
    logic [YW-1:0]    y1;
    logic [CNT_W-1:0] cnt;
  } bbox_t;

  function automatic hdmi_t hdmi_unpack(input logic [PACK_W-1:0] p);
    return hdmi_t'(p);
  endfunction

  function automatic logic [PACK_W-1:0] hdmi_pack(input hdmi_t h);
    return PACK_W'(h);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/target_bbox_if.sv
// Pixel pack in/out plus published box; slave side is the detector, master side feeds it.
interface target_bbox_if;
  import aimbot_pkg::*;

  logic [PACK_W-1:0] i_pack;
  logic [PACK_W-1:0] o_pack;
  logic              box_valid;
  logic [XW-1:0]     box_x0;
  logic [XW-1:0]     box_x1;
  logic [YW-1:0]     box_y0;
  logic [YW-1:0]     box_y1;
  logic [CNT_W-1:0]  hit_cnt;
  logic              frame_stb;

  modport master (
    output i_pack,
    input  o_pack, box_valid, box_x0, box_x1, box_y0, box_y1, hit_cnt, frame_stb
  );

  modport slave (
    input  i_pack,
    output o_pack, box_valid, box_x0, box_x1, box_y0, box_y1, hit_cnt, frame_stb
  );

endinterface

// File: rtl/bbox_accum.sv
// Per-frame min/max/count accumulator; publishes and re-arms on the frame edge (1 clk), no backpressure.
module bbox_accum
  import aimbot_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          hit_i,
  input  logic          edge_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output bbox_t         box_o,
  output logic          stb_o
);

  logic [XW-1:0]    acc_x0_q, acc_x0_d, acc_x1_q, acc_x1_d;
  logic [YW-1:0]    acc_y0_q, acc_y0_d, acc_y1_q, acc_y1_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  bbox_t            box_q, box_d;
  logic             stb_q, stb_d;

  always_comb begin
    acc_x0_d  = acc_x0_q;
    acc_x1_d  = acc_x1_q;
    acc_y0_d  = acc_y0_q;
    acc_y1_d  = acc_y1_q;
    acc_cnt_d = acc_cnt_q;
    box_d     = box_q;
    stb_d     = 1'b0;
    // A hit coinciding with the edge belongs to neither frame and is dropped.
    if (edge_i) begin
      box_d.valid = (acc_cnt_q >= MIN_PIXELS);
      box_d.x0    = acc_x0_q;
      box_d.x1    = acc_x1_q;
      box_d.y0    = acc_y0_q;
      box_d.y1    = acc_y1_q;
      box_d.cnt   = acc_cnt_q;
      stb_d       = 1'b1;
      acc_x0_d    = '1;
      acc_x1_d    = '0;
      acc_y0_d    = '1;
      acc_y1_d    = '0;
      acc_cnt_d   = '0;
    end else if (hit_i) begin
      if (x_i < acc_x0_q) acc_x0_d = x_i;
      if (x_i > acc_x1_q) acc_x1_d = x_i;
      if (y_i < acc_y0_q) acc_y0_d = y_i;
      if (y_i > acc_y1_q) acc_y1_d = y_i;
      acc_cnt_d = sat_inc(acc_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_x0_q  <= '1;
      acc_x1_q  <= '0;
      acc_y0_q  <= '1;
      acc_y1_q  <= '0;
      acc_cnt_q <= '0;
      box_q     <= '0;
      stb_q     <= 1'b0;
    end else begin
      acc_x0_q  <= acc_x0_d;
      acc_x1_q  <= acc_x1_d;
      acc_y0_q  <= acc_y0_d;
      acc_y1_q  <= acc_y1_d;
      acc_cnt_q <= acc_cnt_d;
      box_q     <= box_d;
      stb_q     <= stb_d;
    end
  end

  assign box_o = box_q;
  assign stb_o = stb_q;

endmodule

// File: rtl/target_bbox.sv
// Red-target detector: thresholds pixels, tracks per-frame bounding box and outlines the
// previous frame's box on the outgoing pack; o_pack latency 1 clk, no backpressure.
module target_bbox
  import aimbot_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  target_bbox_if.slave bus
);

  hdmi_t px;
  logic  vsync_q;
  logic  hit;
  logic  frame_edge;
  bbox_t box;
  logic  stb;

  assign px = hdmi_unpack(bus.i_pack);

  assign hit = px.href & px.de & (px.r >= R_MIN) & (px.g <= G_MAX) & (px.b <= B_MAX);
  assign frame_edge = px.vsync & ~vsync_q;

  bbox_accum u_accum (
    .clk    (clk),
    .rst    (rst),
    .hit_i  (hit),
    .edge_i (frame_edge),
    .x_i    (px.x),
    .y_i    (px.y),
    .box_o  (box),
    .stb_o  (stb)
  );

  logic  in_x, in_y, on_v, on_h, draw;
  hdmi_t out_d, out_q;

  // Overlay uses the box held right now, so a freshly published box starts on the next pixel.
  assign in_x = (px.x >= box.x0) && (px.x <= box.x1);
  assign in_y = (px.y >= box.y0) && (px.y <= box.y1);
  assign on_v = ((px.x == box.x0) || (px.x == box.x1)) && in_y;
  assign on_h = ((px.y == box.y0) || (px.y == box.y1)) && in_x;
  assign draw = box.valid & px.de & (on_v | on_h);

  always_comb begin
    out_d = px;
    if (draw) {out_d.r, out_d.g, out_d.b} = BOX_RGB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      vsync_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      vsync_q <= px.vsync;
    end
  end

  assign bus.o_pack    = hdmi_pack(out_q);
  assign bus.box_valid = box.valid;
  assign bus.box_x0    = box.x0;
  assign bus.box_x1    = box.x1;
  assign bus.box_y0    = box.y0;
  assign bus.box_y1    = box.y1;
  assign bus.hit_cnt   = box.cnt;
  assign bus.frame_stb = stb;

endmodule
